// File: rtl/ascon_block_packer_if.sv
// Byte-stream in / block-out bus between the ASCON feeder and its neighbours.
// master drives bytes and block flow control; slave is the packer.
interface ascon_block_packer_if #(
    parameter int RATE_BYTES = 16
);
    logic [7:0]              byte_i;
    logic                    byte_valid_i;
    logic                    byte_last_i;
    logic                    byte_empty_i;
    logic                    byte_ready_o;
    logic                    blk_ready_i;
    logic [8*RATE_BYTES-1:0] data_o;
    logic                    data_valid_o;
    logic                    data_last_o;
    logic                    data_type_o;
    logic                    busy_o;

    modport master (
        output byte_i, byte_valid_i, byte_last_i, byte_empty_i, blk_ready_i,
        input  byte_ready_o, data_o, data_valid_o, data_last_o, data_type_o, busy_o
    );

    modport slave (
        input  byte_i, byte_valid_i, byte_last_i, byte_empty_i, blk_ready_i,
        output byte_ready_o, data_o, data_valid_o, data_last_o, data_type_o, busy_o
    );
endinterface

// File: rtl/ascon_block_packer.sv
// Packs an AD-then-PT byte stream into little-endian rate blocks with 10* padding
// and hands each block to the ASCON core as a one-cycle pulse.
module ascon_block_packer #(
    parameter int RATE_BYTES = 16
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    ascon_block_packer_if.slave  bus
);
    localparam int BW = 8 * RATE_BYTES;
    localparam int CW = $clog2(RATE_BYTES);

    typedef enum logic [1:0] {COLLECT, HOLD, EMIT} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   acc;
    logic [BW-1:0]   data_q;
    logic [BW-1:0]   block_nxt;
    logic            phase;
    logic            last_q;
    logic            type_q;
    logic            pad_pend;

    logic            accept;
    logic            is_empty;
    logic            full;
    logic            skip_ad;
    logic            go_hold;
    logic            padded;
    int              pad_pos;

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        accept   = (state == COLLECT) && bus.byte_valid_i;
        is_empty = bus.byte_last_i && bus.byte_empty_i;
        full     = (cnt == CW'(RATE_BYTES - 1));
        // An empty AD phase produces no block at all; an empty PT phase still needs the pad block.
        skip_ad  = accept && is_empty && (cnt == '0) && !phase;
        go_hold  = accept && !skip_ad && (bus.byte_last_i || full);
        padded   = is_empty || (bus.byte_last_i && !full);
        pad_pos  = int'(cnt) + (is_empty ? 0 : 1);

        block_nxt = acc;
        if (!is_empty)
            block_nxt[8*cnt +: 8] = bus.byte_i;
        if (padded) begin
            for (int i = 0; i < RATE_BYTES; i++) begin
                if (i == pad_pos)
                    block_nxt[8*i +: 8] = 8'h01;
                else if (i > pad_pos)
                    block_nxt[8*i +: 8] = 8'h00;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)
            state <= COLLECT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (go_hold)         state_nxt = HOLD;
            HOLD:    if (bus.blk_ready_i) state_nxt = EMIT;
            EMIT:    state_nxt = pad_pend ? HOLD : COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        bus.byte_ready_o = (state == COLLECT);
        bus.data_valid_o = (state == EMIT);
        bus.busy_o       = (state != COLLECT) || (cnt != '0);
        bus.data_o       = data_q;
        bus.data_last_o  = last_q;
        bus.data_type_o  = type_q;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt      <= '0;
            data_q   <= '0;
            phase    <= 1'b0;
            last_q   <= 1'b0;
            type_q   <= 1'b0;
            pad_pend <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (skip_ad) begin
                        phase <= 1'b1;
                    end else if (go_hold) begin
                        data_q   <= block_nxt;
                        last_q   <= padded;
                        type_q   <= phase;
                        pad_pend <= full && bus.byte_last_i && !is_empty;
                        cnt      <= '0;
                    end else if (accept) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                EMIT: begin
                    if (pad_pend) begin
                        data_q   <= BW'(1);
                        last_q   <= 1'b1;
                        pad_pend <= 1'b0;
                    end else if (last_q) begin
                        phase <= ~phase;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the byte accumulator is plain storage and is not reset; cnt alone decides which bytes are live.
    always_ff @(posedge clock_i) begin
        if (accept && !is_empty && !go_hold)
            acc[8*cnt +: 8] <= bus.byte_i;
    end
endmodule

// File: tb/tb_ascon_block_packer.sv
// Directed bench for ascon_block_packer: table of single-phase messages plus
// hand sequences for latency, back-pressure and mid-stream reset.
module tb_ascon_block_packer;
    localparam int RB = 16;
    localparam int BW = 8 * RB;

    typedef struct packed {
        logic [BW-1:0] data;
        logic          last;
        logic          typ;
    } blk_t;

    typedef struct {
        string         name;
        logic          ptype;
        int            len;
        logic [7:0]    base;
        int            nblk;
        logic [BW-1:0] first_blk;
        logic [BW-1:0] last_blk;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    blk_t got[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    ascon_block_packer_if #(.RATE_BYTES(RB)) bus ();

    ascon_block_packer #(.RATE_BYTES(RB)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    always @(negedge clk)
        if (!rst && bus.data_valid_o === 1'b1)
            got.push_back({bus.data_o, bus.data_last_o, bus.data_type_o});

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last, input logic empty);
        int n = 0;
        bus.byte_i       = b;
        bus.byte_valid_i = 1'b1;
        bus.byte_last_i  = last;
        bus.byte_empty_i = empty;
        while (bus.byte_ready_o !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("send_timeout", BW'(bus.byte_ready_o), BW'(1));
        @(posedge clk); #1;
        bus.byte_valid_i = 1'b0;
        bus.byte_last_i  = 1'b0;
        bus.byte_empty_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy_o !== 1'b0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle", BW'(bus.busy_o), BW'(0));
    endtask

    task automatic send_msg(input int len, input logic [7:0] base);
        if (len == 0) begin
            send(8'h00, 1'b1, 1'b1);
        end else begin
            for (int i = 0; i < len; i++) begin
                send(8'(int'(base) + i), (i == len - 1), 1'b0);
                if (i % 5 == 4) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    initial begin
        int            b0;
        int            bad;
        logic [BW-1:0] d0;
        logic [7:0]    alice[12];

        vecs[0] = '{"ad3",    1'b0, 3,  8'h10, 1, 128'h00000000_00000000_00000000_01121110,
                                               128'h00000000_00000000_00000000_01121110};
        vecs[1] = '{"pt47",   1'b1, 47, 8'h00, 3, 128'h0F0E0D0C_0B0A0908_07060504_03020100,
                                               128'h012E2D2C_2B2A2928_27262524_23222120};
        vecs[2] = '{"ad16",   1'b0, 16, 8'h80, 2, 128'h8F8E8D8C_8B8A8988_87868584_83828180,
                                               128'h1};
        vecs[3] = '{"pt15",   1'b1, 15, 8'hF0, 1, 128'h01FEFDFC_FBFAF9F8_F7F6F5F4_F3F2F1F0,
                                               128'h01FEFDFC_FBFAF9F8_F7F6F5F4_F3F2F1F0};
        vecs[4] = '{"ad_empty", 1'b0, 0, 8'h00, 0, 128'h0, 128'h0};
        vecs[5] = '{"pt_empty", 1'b1, 0, 8'h00, 1, 128'h1, 128'h1};
        vecs[6] = '{"ad1",    1'b0, 1,  8'hA5, 1, 128'h1A5, 128'h1A5};
        vecs[7] = '{"pt32",   1'b1, 32, 8'h40, 3, 128'h4F4E4D4C_4B4A4948_47464544_43424140,
                                               128'h1};
        alice = '{8'h41, 8'h6C, 8'h69, 8'h63, 8'h65, 8'h20, 8'h74, 8'h6F, 8'h20, 8'h42, 8'h6F, 8'h62};

        bus.byte_i       = 8'h00;
        bus.byte_valid_i = 1'b0;
        bus.byte_last_i  = 1'b0;
        bus.byte_empty_i = 1'b0;
        bus.blk_ready_i  = 1'b1;

        #12;
        check("reset_state",
              {bus.data_o[BW-6:0], bus.data_valid_o, bus.data_last_o, bus.data_type_o, bus.busy_o, bus.byte_ready_o},
              BW'(1));
        check("reset_data_hi", BW'(bus.data_o[BW-1:BW-5]), BW'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            b0 = got.size();
            send_msg(vecs[v].len, vecs[v].base);
            wait_idle();
            check({vecs[v].name, "_nblk"}, BW'(got.size() - b0), BW'(vecs[v].nblk));
            if (got.size() - b0 == vecs[v].nblk && vecs[v].nblk > 0) begin
                check({vecs[v].name, "_first"}, got[b0].data, vecs[v].first_blk);
                check({vecs[v].name, "_lastblk"}, got[b0 + vecs[v].nblk - 1].data, vecs[v].last_blk);
                for (int j = 0; j < vecs[v].nblk; j++) begin
                    check({vecs[v].name, "_lastflag"}, BW'(got[b0 + j].last), BW'(j == vecs[v].nblk - 1));
                    check({vecs[v].name, "_type"}, BW'(got[b0 + j].typ), BW'(vecs[v].ptype));
                end
            end
        end

        // AD "Alice to Bob" with latency check on the final byte.
        b0 = got.size();
        for (int i = 0; i < 12; i++) send(alice[i], (i == 11), 1'b0);
        check("lat_hold", BW'({bus.byte_ready_o, bus.data_valid_o}), BW'(0));
        @(posedge clk); #1;
        check("lat_emit", BW'(bus.data_valid_o), BW'(1));
        wait_idle();
        check("alice_nblk", BW'(got.size() - b0), BW'(1));
        if (got.size() > b0) begin
            check("alice_data", got[b0].data, 128'h00000001_626F4220_6F742065_63696C41);
            check("alice_flags", BW'({got[b0].last, got[b0].typ}), BW'(2'b10));
        end

        // Back-pressure: block parked in HOLD for 10 cycles.
        bus.blk_ready_i = 1'b0;
        b0 = got.size();
        send(8'hAA, 1'b0, 1'b0);
        send(8'hBB, 1'b1, 1'b0);
        d0  = bus.data_o;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.byte_ready_o !== 1'b0 || bus.data_valid_o !== 1'b0 || bus.data_o !== d0) bad++;
        end
        check("hold_stable", BW'(bad), BW'(0));
        check("hold_data", bus.data_o, 128'h0001BBAA);
        check("hold_nopulse", BW'(got.size() - b0), BW'(0));
        bus.blk_ready_i = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("release_one_pulse", BW'(got.size() - b0), BW'(1));
        if (got.size() > b0)
            check("release_flags", BW'({got[b0].last, got[b0].typ}), BW'(2'b11));
        wait_idle();

        // Reset mid-PT: phase returns to AD and the partial block is lost.
        send(8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) send(8'h60 + 8'(i), 1'b0, 1'b0);
        check("pre_reset_busy", BW'(bus.busy_o), BW'(1));
        rst = 1'b1;
        #2;
        check("mid_reset_state",
              {bus.data_o[BW-6:0], bus.data_valid_o, bus.data_last_o, bus.data_type_o, bus.busy_o, bus.byte_ready_o},
              BW'(1));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        b0 = got.size();
        send_msg(12, 8'h30);
        wait_idle();
        check("post_reset_nblk", BW'(got.size() - b0), BW'(1));
        if (got.size() > b0) begin
            check("post_reset_data", got[b0].data, 128'h00000001_3B3A3938_37363534_33323130);
            check("post_reset_flags", BW'({got[b0].last, got[b0].typ}), BW'(2'b10));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
